ofifo_align: RTL and testbench

- Output FIFO that sits directly downstream of a row of MAC tiles.
- Captures the per-column partial sums that the array drives south. Each column's valid strobe arrives skewed by one cycle per column.
- Re-aligns the columns so that one read returns a complete row vector to the SFU/accumulation stage.
- Built as `col` independent column FIFOs with a shared, all-columns-ready read port.

---
 rtl/ofifo_align_pkg.sv | 12 +
 rtl/ofifo_col.sv | 40 ++++
 rtl/ofifo_align.sv | 47 ++++
 tb/tb_ofifo_align.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ofifo_align_pkg.sv
// ofifo_align_pkg: shared defaults and derived widths for the output FIFO
package ofifo_align_pkg;
  localparam int psum_bw_def = 16;
  localparam int col_def = 8;
  localparam int depth_def = 64;
  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/ofifo_col.sv
// ofifo_col: one first-word-fall-through column FIFO
module ofifo_col
  import ofifo_align_pkg::*;
#(
  parameter int psum_bw = psum_bw_def,
  parameter int depth = depth_def,
  localparam int pw = ptr_w(depth),
  localparam int cw = cnt_w(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] din,
  input  logic               wr,
  input  logic               rd,
  output logic [psum_bw-1:0] dout,
  output logic [cw-1:0]      count,
  output logic               wr_drop
);
  logic [psum_bw-1:0] mem [depth];
  logic [pw-1:0] wptr, rptr;
  logic wr_acc;
  // a full column still takes a write when the shared read frees a slot
  always_comb wr_acc = wr & ((count < cw'(depth)) | rd);
  assign wr_drop = wr & ~wr_acc;
  assign dout = mem[rptr];
  // storage has no reset; contents are only visible behind a non-zero count
  always_ff @(posedge clk)
    if (reset && wr_acc) mem[wptr] <= din;
  // pointers and occupancy; rd arrives already qualified by the top
  always_ff @(posedge clk)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + pw'(1);
      if (rd) rptr <= rptr + pw'(1);
      count <= count + cw'(wr_acc) - cw'(rd);
    end
endmodule

// File: rtl/ofifo_align.sv
// ofifo_align: per-column FIFOs re-aligning skewed MAC column outputs into rows
module ofifo_align
  import ofifo_align_pkg::*;
#(
  parameter int psum_bw = psum_bw_def,
  parameter int col = col_def,
  parameter int depth = depth_def
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_ovf
);
  localparam int cw = cnt_w(depth);
  logic [cw-1:0] count [col];
  logic [col-1:0] wr_drop, nz, zr, fl;
  logic rd_acc;
  assign rd_acc = rd & o_valid;
  for (genvar i = 0; i < col; i++) begin : g_col
    ofifo_col #(.psum_bw(psum_bw), .depth(depth)) u_col (
      .clk(clk),
      .reset(reset),
      .din(in[psum_bw*i +: psum_bw]),
      .wr(wr[i]),
      .rd(rd_acc),
      .dout(out[psum_bw*i +: psum_bw]),
      .count(count[i]),
      .wr_drop(wr_drop[i])
    );
    assign nz[i] = count[i] != '0;
    assign zr[i] = count[i] == '0;
    assign fl[i] = count[i] == cw'(depth);
  end
  assign o_valid = &nz;
  assign o_empty = &zr;
  assign o_full = |fl;
  // sticky record of any dropped write, cleared only by reset
  always_ff @(posedge clk)
    if (!reset) o_ovf <= 1'b0;
    else if (|wr_drop) o_ovf <= 1'b1;
endmodule

// File: tb/tb_ofifo_align.sv
// tb_ofifo_align: table vectors, corner sequences and random traffic against a queue model
module tb_ofifo_align;
  localparam int PB = 16;
  localparam int NC = 8;
  localparam int DP = 64;
  logic clk, reset, rd;
  logic [PB*NC-1:0] in, out;
  logic [NC-1:0] wr;
  logic o_valid, o_full, o_empty, o_ovf;
  int n_chk = 0;
  int n_fail = 0;

  ofifo_align #(.psum_bw(PB), .col(NC), .depth(DP)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty), .o_ovf(o_ovf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  logic [PB-1:0] mq [NC][$];
  logic m_ovf = 0;

  task automatic chk(input string nm, input logic [PB*NC-1:0] act, input logic [PB*NC-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [PB*NC-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_update(input logic r, input logic [NC-1:0] w, input logic [PB*NC-1:0] d, input logic rdi);
    bit v, ra, wa;
    if (!r) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_ovf = 0;
    end else begin
      v = 1;
      for (int c = 0; c < NC; c++) if (mq[c].size() == 0) v = 0;
      ra = rdi & v;
      for (int c = 0; c < NC; c++) begin
        wa = w[c] && (mq[c].size() < DP || ra);
        if (ra) void'(mq[c].pop_front());
        if (wa) mq[c].push_back(d[PB*c +: PB]);
        if (w[c] && !wa) m_ovf = 1;
      end
    end
  endtask

  task automatic model_check();
    bit v, e, f;
    logic [PB*NC-1:0] mo;
    v = 1; e = 1; f = 0; mo = '0;
    for (int c = 0; c < NC; c++) begin
      if (mq[c].size() == 0) v = 0;
      else begin
        e = 0;
        mo[PB*c +: PB] = mq[c][0];
      end
      if (mq[c].size() == DP) f = 1;
    end
    chk("m_valid", o_valid, v);
    chk("m_empty", o_empty, e);
    chk("m_full", o_full, f);
    chk("m_ovf", o_ovf, m_ovf);
    if (v) chk("m_out", out, mo);
  endtask

  task automatic step(input logic r, input logic [NC-1:0] w, input logic [PB*NC-1:0] d, input logic rdi);
    reset = r; wr = w; in = d; rd = rdi;
    @(posedge clk);
    model_update(r, w, d, rdi);
    #1;
    model_check();
  endtask

  typedef struct {
    logic r;
    logic [NC-1:0] w;
    logic [PB*NC-1:0] d;
    logic rdi;
    logic e_valid, e_empty, e_full, e_ovf;
    logic [PB*NC-1:0] e_out;
  } vec_t;
  vec_t tbl [13];

  initial begin
    logic [PB*NC-1:0] skew, first, row, er;
    logic [PB*NC-1:0] rows [DP];
    logic [NC-1:0] w;
    int k;
    reset = 0; wr = '0; in = '0; rd = 0;
    for (int c = 0; c < NC; c++) skew[PB*c +: PB] = 16'h0100 + 16'(c);
    for (int j = 0; j < 13; j++) tbl[j] = '{1'b1, '0, skew, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0};
    tbl[0].r = 0;
    tbl[1].r = 0;
    tbl[2].rdi = 1;
    tbl[3].rdi = 1;
    for (int j = 0; j < 8; j++) begin
      tbl[4+j].w = 8'(1 << j);
      tbl[4+j].e_empty = 0;
    end
    tbl[11].e_valid = 1;
    tbl[11].e_out = skew;
    tbl[12].rdi = 1;
    for (int j = 0; j < 13; j++) begin
      step(tbl[j].r, tbl[j].w, tbl[j].d, tbl[j].rdi);
      chk($sformatf("tbl%0d_valid", j), o_valid, tbl[j].e_valid);
      chk($sformatf("tbl%0d_empty", j), o_empty, tbl[j].e_empty);
      chk($sformatf("tbl%0d_full", j), o_full, tbl[j].e_full);
      chk($sformatf("tbl%0d_ovf", j), o_ovf, tbl[j].e_ovf);
      if (tbl[j].e_valid) chk($sformatf("tbl%0d_out", j), out, tbl[j].e_out);
    end
    k = 0;
    for (int t = 0; t < 30; t++) begin
      w = '0; row = '0;
      for (int i = 0; i < NC; i++)
        if (t - i >= 0 && t - i < 3) begin
          w[i] = 1;
          row[PB*i +: PB] = 16'((t - i) * 16 + i);
        end
      if (o_valid) begin
        for (int i = 0; i < NC; i++) er[PB*i +: PB] = 16'(k * 16 + i);
        chk($sformatf("stream_row%0d", k), out, er);
        k++;
      end
      step(1, w, row, o_valid);
    end
    chk("stream_rows", 128'(k), 128'd3);
    chk("stream_empty", o_empty, 1'b1);
    for (int j = 0; j < DP; j++) begin
      rows[j] = rnd_row();
      step(1, '1, rows[j], 0);
    end
    first = rows[0];
    chk("full_set", o_full, 1'b1);
    step(1, '1, rnd_row(), 0);
    chk("ovf_set", o_ovf, 1'b1);
    chk("ovf_head", out, first);
    for (int j = 0; j < DP; j++) begin
      chk($sformatf("drain%0d", j), out, rows[j]);
      step(1, '0, '0, 1);
    end
    chk("drain_empty", o_empty, 1'b1);
    for (int j = 0; j < 10; j++) begin
      row = rnd_row();
      step(1, '1, row, 0);
      chk($sformatf("wrap%0d", j), out, row);
      step(1, '0, '0, 1);
    end
    chk("ovf_sticky", o_ovf, 1'b1);
    step(0, '0, '0, 0);
    chk("rst_ovf", o_ovf, 1'b0);
    step(1, '1, rnd_row(), 0);
    for (int j = 1; j < DP; j++) step(1, 8'h01, rnd_row(), 0);
    chk("c0_full", o_full, 1'b1);
    step(1, 8'h01, rnd_row(), 1);
    chk("c0_rw_full", o_full, 1'b1);
    chk("c0_rw_ovf", o_ovf, 1'b0);
    for (int j = 0; j < 5; j++) step(1, '1, rnd_row(), 0);
    step(0, '0, '0, 0);
    chk("mid_rst_empty", o_empty, 1'b1);
    row = rnd_row();
    step(1, '1, row, 0);
    chk("mid_rst_valid", o_valid, 1'b1);
    chk("mid_rst_row", out, row);
    step(1, '0, '0, 1);
    chk("mid_rst_only", o_empty, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      bit fill;
      fill = ((n / 300) % 2) == 0;
      for (int c = 0; c < NC; c++) w[c] = $urandom_range(0, 99) < (fill ? 85 : 30);
      step($urandom_range(0, 399) != 0, w, rnd_row(), $urandom_range(0, 99) < (fill ? 15 : 80));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
